// File: rtl/gps_acq_corr.sv
// GPS C/A code-phase acquisition correlator: carrier wipe-off with a local NCO,
// despreading with a local C/A replica, serial sweep over code-phase hypotheses.
module gps_acq_corr #(
   parameter int NUM_HYP   = 1023,
   parameter int DWELL_LEN = 16368,
   parameter int SPC       = 16
) (
   input  logic        clk_in,
   input  logic        rst_in_n,
   input  logic        sample_in,
   input  logic        sample_vld_in,
   input  logic [4:0]  n_sat_in,
   input  logic [7:0]  doppler_in,
   input  logic [15:0] threshold_in,
   input  logic        start_in,
   input  logic        abort_in,
   output logic        busy_out,
   output logic        done_out,
   output logic        found_out,
   output logic [9:0]  peak_phase_out,
   output logic [15:0] peak_mag_out
);

   localparam int CW = $clog2(DWELL_LEN + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DWELL = 3'd1,
      EVAL  = 3'd2,
      SLIP  = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t             state_r;
   logic [4:0]         prn_r;
   logic [13:0]        word_r;
   logic [9:0]         hyp_r;
   logic [CW-1:0]      cnt_r;
   logic [15:0]        max_r;
   logic signed [14:0] acc_i_r;
   logic signed [14:0] acc_q_r;
   logic [3:0]         pre_r;
   logic [10:1]        g1_r;
   logic [10:1]        g2_r;
   logic [13:0]        phase_r;
   logic               busy_r;
   logic               done_r;
   logic               found_r;
   logic [9:0]         peak_phase_r;
   logic [15:0]        peak_mag_r;

   logic        clr_s;
   logic        nco_en_s;
   logic        adv_s;
   logic        gc_s;
   logic        step_i_s;
   logic        step_q_s;
   logic [14:0] abs_i_s;
   logic [14:0] abs_q_s;
   logic [15:0] mag_s;
   logic        upd_s;
   logic [15:0] new_max_s;

   // G2 phase-selector taps per PRN; code 0 selects PRN 32
   function automatic logic g2_tap(input logic [10:1] g2, input logic [4:0] prn);
      logic t;
      case (prn)
         5'd1:    t = g2[2] ^ g2[6];
         5'd2:    t = g2[3] ^ g2[7];
         5'd3:    t = g2[4] ^ g2[8];
         5'd4:    t = g2[5] ^ g2[9];
         5'd5:    t = g2[1] ^ g2[9];
         5'd6:    t = g2[2] ^ g2[10];
         5'd7:    t = g2[1] ^ g2[8];
         5'd8:    t = g2[2] ^ g2[9];
         5'd9:    t = g2[3] ^ g2[10];
         5'd10:   t = g2[2] ^ g2[3];
         5'd11:   t = g2[3] ^ g2[4];
         5'd12:   t = g2[5] ^ g2[6];
         5'd13:   t = g2[6] ^ g2[7];
         5'd14:   t = g2[7] ^ g2[8];
         5'd15:   t = g2[8] ^ g2[9];
         5'd16:   t = g2[9] ^ g2[10];
         5'd17:   t = g2[1] ^ g2[4];
         5'd18:   t = g2[2] ^ g2[5];
         5'd19:   t = g2[3] ^ g2[6];
         5'd20:   t = g2[4] ^ g2[7];
         5'd21:   t = g2[5] ^ g2[8];
         5'd22:   t = g2[6] ^ g2[9];
         5'd23:   t = g2[1] ^ g2[3];
         5'd24:   t = g2[4] ^ g2[6];
         5'd25:   t = g2[5] ^ g2[7];
         5'd26:   t = g2[6] ^ g2[8];
         5'd27:   t = g2[7] ^ g2[9];
         5'd28:   t = g2[8] ^ g2[10];
         5'd29:   t = g2[1] ^ g2[6];
         5'd30:   t = g2[2] ^ g2[7];
         5'd31:   t = g2[3] ^ g2[8];
         default: t = g2[4] ^ g2[9];
      endcase
      return t;
   endfunction

   // Replica control, correlation products and the magnitude/peak compare
   always_comb begin
      clr_s     = (state_r == IDLE) && start_in;
      nco_en_s  = sample_vld_in && ((state_r == DWELL) || (state_r == EVAL) || (state_r == SLIP));
      adv_s     = sample_vld_in && ((state_r == DWELL) || (state_r == EVAL));
      gc_s      = g1_r[10] ^ g2_tap(g2_r, prn_r);
      step_i_s  = sample_in ^ gc_s ^ phase_r[13];
      step_q_s  = sample_in ^ gc_s ^ phase_r[13] ^ phase_r[12];
      abs_i_s   = acc_i_r[14] ? 15'(-acc_i_r) : 15'(acc_i_r);
      abs_q_s   = acc_q_r[14] ? 15'(-acc_q_r) : 15'(acc_q_r);
      mag_s     = {1'b0, abs_i_s} + {1'b0, abs_q_s};
      upd_s     = mag_s > max_r;
      new_max_s = upd_s ? mag_s : max_r;
   end

   // Local carrier NCO and C/A replica; frozen outside DWELL/EVAL, which creates the slip
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         phase_r <= 14'd0;
         pre_r   <= 4'd0;
         g1_r    <= 10'h3FF;
         g2_r    <= 10'h3FF;
      end else if (clr_s) begin
         phase_r <= 14'd0;
         pre_r   <= 4'd0;
         g1_r    <= 10'h3FF;
         g2_r    <= 10'h3FF;
      end else begin
         if (nco_en_s) begin
            phase_r <= phase_r + word_r;
         end
         if (adv_s) begin
            if (pre_r == 4'(SPC - 1)) begin
               pre_r <= 4'd0;
               g1_r  <= {g1_r[9:1], g1_r[3] ^ g1_r[10]};
               g2_r  <= {g2_r[9:1], g2_r[2] ^ g2_r[3] ^ g2_r[6] ^ g2_r[8] ^ g2_r[9] ^ g2_r[10]};
            end else begin
               pre_r <= pre_r + 4'd1;
            end
         end
      end
   end

   // Sweep sequencer with accumulators and registered result outputs
   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state_r      <= IDLE;
         prn_r        <= 5'd0;
         word_r       <= 14'd0;
         hyp_r        <= 10'd0;
         cnt_r        <= '0;
         max_r        <= 16'd0;
         acc_i_r      <= 15'sd0;
         acc_q_r      <= 15'sd0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         found_r      <= 1'b0;
         peak_phase_r <= 10'd0;
         peak_mag_r   <= 16'd0;
      end else begin
         done_r <= 1'b0;
         if ((state_r != IDLE) && abort_in) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (start_in) begin
                     prn_r        <= n_sat_in;
                     word_r       <= 14'd8000 + {6'd0, doppler_in};
                     hyp_r        <= 10'd0;
                     cnt_r        <= '0;
                     max_r        <= 16'd0;
                     acc_i_r      <= 15'sd0;
                     acc_q_r      <= 15'sd0;
                     found_r      <= 1'b0;
                     peak_phase_r <= 10'd0;
                     peak_mag_r   <= 16'd0;
                     busy_r       <= 1'b1;
                     state_r      <= DWELL;
                  end
               end
               DWELL: begin
                  if (sample_vld_in) begin
                     acc_i_r <= acc_i_r + (step_i_s ? -15'sd1 : 15'sd1);
                     acc_q_r <= acc_q_r + (step_q_s ? -15'sd1 : 15'sd1);
                     if (cnt_r == CW'(DWELL_LEN - 1)) begin
                        cnt_r   <= '0;
                        state_r <= EVAL;
                     end else begin
                        cnt_r <= cnt_r + 1'b1;
                     end
                  end
               end
               EVAL: begin
                  max_r <= new_max_s;
                  if (upd_s) begin
                     peak_phase_r <= hyp_r;
                  end
                  if (hyp_r == 10'(NUM_HYP - 1)) begin
                     done_r     <= 1'b1;
                     busy_r     <= 1'b0;
                     peak_mag_r <= new_max_s;
                     found_r    <= (new_max_s >= threshold_in);
                     state_r    <= DONE;
                  end else begin
                     acc_i_r <= 15'sd0;
                     acc_q_r <= 15'sd0;
                     state_r <= SLIP;
                  end
               end
               SLIP: begin
                  if (sample_vld_in) begin
                     if (cnt_r == CW'(SPC - 1)) begin
                        cnt_r   <= '0;
                        hyp_r   <= hyp_r + 10'd1;
                        state_r <= DWELL;
                     end else begin
                        cnt_r <= cnt_r + 1'b1;
                     end
                  end
               end
               DONE: begin
                  state_r <= IDLE;
               end
               default: begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy_out       = busy_r;
   assign done_out       = done_r;
   assign found_out      = found_r;
   assign peak_phase_out = peak_phase_r;
   assign peak_mag_out   = peak_mag_r;

endmodule

// File: tb/tb_gps_acq_corr.sv
// Directed bench for gps_acq_corr on a reduced sweep: the bench plays the
// transmitter (C/A code of PRN 3 on a square-wave carrier) and predicts results.
module tb_gps_acq_corr;

   localparam int NH   = 4;
   localparam int DL   = 2046;
   localparam int SP   = 2;
   localparam int WORD = 8032;
   localparam int HYPW = DL + 1 + SP;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sample_in;
   logic        sample_vld_in;
   logic [4:0]  n_sat_in;
   logic [7:0]  doppler_in;
   logic [15:0] threshold_in;
   logic        start_in;
   logic        abort_in;
   logic        busy_out;
   logic        done_out;
   logic        found_out;
   logic [9:0]  peak_phase_out;
   logic [15:0] peak_mag_out;

   int checks   = 0;
   int failures = 0;
   int done_e;
   int mag2;
   bit code_arr[1023];

   gps_acq_corr #(.NUM_HYP(NH), .DWELL_LEN(DL), .SPC(SP)) dut (
      .clk_in        (clk),
      .rst_in_n      (rst_n),
      .sample_in     (sample_in),
      .sample_vld_in (sample_vld_in),
      .n_sat_in      (n_sat_in),
      .doppler_in    (doppler_in),
      .threshold_in  (threshold_in),
      .start_in      (start_in),
      .abort_in      (abort_in),
      .busy_out      (busy_out),
      .done_out      (done_out),
      .found_out     (found_out),
      .peak_phase_out(peak_phase_out),
      .peak_mag_out  (peak_mag_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference C/A generator written with per-stage integer registers
   task automatic gen_code(input int t1, input int t2);
      int g1[11];
      int g2[11];
      int f1, f2;
      for (int k = 1; k <= 10; k++) begin
         g1[k] = 1;
         g2[k] = 1;
      end
      for (int c = 0; c < 1023; c++) begin
         code_arr[c] = bit'(g1[10] ^ g2[t1] ^ g2[t2]);
         f1 = g1[3] ^ g1[10];
         f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
         for (int k = 10; k >= 2; k--) begin
            g1[k] = g1[k-1];
            g2[k] = g2[k-1];
         end
         g1[1] = f1;
         g2[1] = f2;
      end
   endtask

   function automatic bit input_bit(input int n, input int d);
      int chip, ph;
      chip = ((n / SP) - d) % 1023;
      if (chip < 0) chip += 1023;
      ph = (n * WORD) % 16384;
      return code_arr[chip] ^ ph[13];
   endfunction

   // Aligned hypothesis: I is a full +DL, Q integrates the quadrature residue
   function automatic int exp_mag(input int d);
      int q, ph, base;
      q = 0;
      base = d * HYPW;
      for (int i = 0; i < DL; i++) begin
         ph = ((base + i) * WORD) % 16384;
         q += ph[12] ? -1 : 1;
      end
      if (q < 0) q = -q;
      return DL + q;
   endfunction

   task automatic start_run(input int prn, input int thr, input bit abt);
      n_sat_in     = 5'(prn);
      doppler_in   = 8'h20;
      threshold_in = 16'(thr);
      start_in     = 1'b1;
      abort_in     = abt;
      @(posedge clk); #1;
      start_in = 1'b0;
      abort_in = 1'b0;
      check("busy_after_start", busy_out, 1);
   endtask

   task automatic stream(input int d, input bit rnd, input int abort_e, input int limit);
      int n, e;
      bit v;
      n = 0;
      e = 0;
      done_e = -1;
      while (e < limit && done_e < 0) begin
         start_in = (e == 100);
         abort_in = (e == abort_e);
         v = 1'b1;
         if (rnd && (n % HYPW) != DL) v = bit'($urandom_range(0, 1));
         sample_vld_in = v;
         sample_in = v ? input_bit(n, d) : 1'b0;
         @(posedge clk); #1;
         if (v) n++;
         e++;
         if (abort_e >= 0 && e == abort_e + 1) check("abort_busy", busy_out, 0);
         if (done_out) done_e = e;
      end
      start_in      = 1'b0;
      abort_in      = 1'b0;
      sample_vld_in = 1'b0;
      sample_in     = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      sample_in = 1'b0; sample_vld_in = 1'b0; n_sat_in = 5'd0; doppler_in = 8'd0;
      threshold_in = 16'd0; start_in = 1'b0; abort_in = 1'b0;
      gen_code(4, 8);
      mag2 = exp_mag(2);
      #23;
      check("rst_busy", busy_out, 0);
      check("rst_done", done_out, 0);
      check("rst_found", found_out, 0);
      check("rst_phase", peak_phase_out, 0);
      check("rst_mag", peak_mag_out, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // clean PRN 3, code lag 2 chips, valid tied high, stray start at e=100
      start_run(3, 1500, 1'b0);
      stream(2, 1'b0, -1, 9000);
      check("done_edge", done_e, 8194);
      check("busy_at_done", busy_out, 0);
      check("clean_phase", peak_phase_out, 2);
      check("clean_mag", peak_mag_out, mag2);
      check("clean_found", found_out, 1);
      start_in = 1'b1;
      @(posedge clk); #1;
      start_in = 1'b0;
      check("start_in_done_ignored", busy_out, 0);
      check("done_single_pulse", done_out, 0);
      check("mag_held", peak_mag_out, mag2);

      // same stimulus with ~50% valid; threshold exactly at the peak
      @(posedge clk); #1;
      start_run(3, mag2, 1'b0);
      stream(2, 1'b1, -1, 40000);
      check("rnd_done_seen", int'(done_e > 0), 1);
      check("rnd_phase", peak_phase_out, 2);
      check("rnd_mag", peak_mag_out, mag2);
      check("rnd_found_at_threshold", found_out, 1);

      // lag 1 chip, abort in the second slip
      @(posedge clk); #1;
      start_run(3, 1500, 1'b0);
      stream(1, 1'b0, 4096, 8400);
      check("abort_no_done", done_e, -1);
      check("abort_phase", peak_phase_out, 1);
      check("abort_mag", peak_mag_out, 0);
      check("abort_found", found_out, 0);

      // start and abort together in IDLE, mismatched replica PRN
      start_run(7, 600, 1'b1);
      stream(2, 1'b0, -1, 9000);
      check("mis_done_edge", done_e, 8194);
      check("mis_found", found_out, 0);
      check("mis_mag_low", int'(peak_mag_out < 16'd600), 1);

      // asynchronous reset in the middle of the third dwell
      @(posedge clk); #1;
      start_run(3, 1500, 1'b0);
      stream(1, 1'b0, -1, 4600);
      check("pre_reset_phase", peak_phase_out, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy_out, 0);
      check("mid_rst_done", done_out, 0);
      check("mid_rst_found", found_out, 0);
      check("mid_rst_phase", peak_phase_out, 0);
      check("mid_rst_mag", peak_mag_out, 0);
      @(negedge clk) rst_n = 1'b1;
      start_run(3, 1500, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
